// File: rtl/blake2_block_sequencer.sv
// blake2_block_sequencer
// Host-side block sequencer for a BLAKE2 compression core. The host strobes
// init/next/final with one block each; blocks are buffered in a small FIFO
// tagged first/last and offered to the core with the running byte counter t.
// The core's digest is captured once the last block has been consumed.
//
// Optional feature: define BLAKE2_SEQ_ERR_EN to build the sticky protocol-error
// flag on err_o. Without it err_o is tied low and no error logic exists.
//
// Port names carry _i/_o suffixes because "final" is a reserved word.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no message since reset, waiting for init
// FILL     | message open, accepting next/final while FIFO has room
// DRAIN    | last block buffered, FIFO emptying into the core
// WAIT_DIG | last block consumed by core, waiting for core_digest_valid
// DONE     | digest held on digest_o, waiting for the next init

module blake2_block_sequencer #(
    parameter int BLOCK_BITS  = 1024,
    parameter int DEPTH       = 8,
    parameter int DIGEST_BITS = 88,
    parameter int CTR_BITS    = 128
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   init_i,
    input  logic                   next_i,
    input  logic                   final_i,
    input  logic [BLOCK_BITS-1:0]  block_i,
    input  logic [CTR_BITS-1:0]    length_i,
    output logic                   ready_o,
    output logic                   digest_valid_o,
    output logic [DIGEST_BITS-1:0] digest_o,
    output logic                   err_o,
    output logic                   core_valid_o,
    output logic [BLOCK_BITS-1:0]  core_block_o,
    output logic                   core_first_o,
    output logic                   core_last_o,
    output logic [CTR_BITS-1:0]    core_t_o,
    input  logic                   core_ready_i,
    input  logic                   core_digest_valid_i,
    input  logic [DIGEST_BITS-1:0] core_digest_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]    DEPTH_C     = CNT_W'(DEPTH);
    localparam logic [CTR_BITS-1:0] BLOCK_BYTES = CTR_BITS'(BLOCK_BITS / 8);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_WAIT_DIG = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t                 state_q;
    logic [CTR_BITS-1:0]    t_q;
    logic [CTR_BITS-1:0]    length_q;
    logic [DIGEST_BITS-1:0] digest_q;
    logic                   digest_valid_q;

    // FIFO storage and bookkeeping
    logic [BLOCK_BITS-1:0]  mem_blk_q [DEPTH];
    logic [DEPTH-1:0]       mem_first_q;
    logic [DEPTH-1:0]       mem_last_q;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q,  count_d;

    // strobe decode
    logic idle_like;
    logic ready_c;
    logic only_init, init_final, only_next, only_final;
    logic acc_init, acc_next, acc_final;
    logic push, push_first, push_last;
    logic pop, head_first, head_last;

    // Decode host strobes against the registered state and FIFO count.
    always_comb begin
        idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE);
        ready_c    = idle_like || ((state_q == ST_FILL) && (count_q < DEPTH_C));

        only_init  =  init_i & ~next_i & ~final_i;
        init_final =  init_i & ~next_i &  final_i;
        only_next  = ~init_i &  next_i & ~final_i;
        only_final = ~init_i & ~next_i &  final_i;

        acc_init   = ready_c & idle_like & (only_init | init_final);
        acc_next   = ready_c & (state_q == ST_FILL) & only_next;
        acc_final  = ready_c & (state_q == ST_FILL) & only_final;

        push       = acc_init | acc_next | acc_final;
        push_first = acc_init;
        push_last  = acc_final | (acc_init & final_i);

        pop        = (count_q != '0) & core_ready_i;
        head_first = mem_first_q[rd_ptr_q];
        head_last  = mem_last_q[rd_ptr_q];
    end

    // Next FIFO pointers and count; push and pop together leave count as is.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO payload storage; contents are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_blk_q[wr_ptr_q]   <= block_i;
            mem_first_q[wr_ptr_q] <= push_first;
            mem_last_q[wr_ptr_q]  <= push_last;
        end
    end

    // Message sequencing FSM with byte counter, length latch and digest capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            t_q            <= '0;
            length_q       <= '0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
        end else begin
            if (push_last) begin
                length_q <= length_i;
            end

            if (acc_init) begin
                t_q <= '0;
            end else if (pop && !head_last) begin
                t_q <= t_q + BLOCK_BYTES;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (acc_init) begin
                        digest_valid_q <= 1'b0;
                        state_q        <= final_i ? ST_DRAIN : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (acc_final) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && head_last) begin
                        state_q <= ST_WAIT_DIG;
                    end
                end
                ST_WAIT_DIG: begin
                    if (core_digest_valid_i) begin
                        digest_q       <= core_digest_i;
                        digest_valid_q <= 1'b1;
                        state_q        <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef BLAKE2_SEQ_ERR_EN
    // Any strobe that is not accepted is a protocol violation.
    logic violation;
    logic err_q;

    assign violation = (init_i | next_i | final_i) & ~push;

    // Sticky error flag, cleared by reset or an accepted init.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (acc_init) begin
            err_q <= 1'b0;
        end else if (violation) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign ready_o        = ready_c;
    assign digest_valid_o = digest_valid_q;
    assign digest_o       = digest_q;
    assign core_valid_o   = (count_q != '0);
    assign core_block_o   = mem_blk_q[rd_ptr_q];
    assign core_first_o   = head_first;
    assign core_last_o    = head_last;
    assign core_t_o       = head_last ? length_q : (t_q + BLOCK_BYTES);

endmodule

// File: tb/tb_blake2_block_sequencer.sv
// tb_blake2_block_sequencer
// Directed scenarios plus randomized strobes against a message-level model:
// a queue of pending blocks with their expected byte offsets, and flags for
// "message open", "final seen" and "waiting for digest".

module tb_blake2_block_sequencer;

    localparam int BLOCK_BITS  = 1024;
    localparam int DEPTH       = 8;
    localparam int DIGEST_BITS = 88;
    localparam int CTR_BITS    = 128;
    localparam logic [127:0] BYTES = 128'd128;

`ifdef BLAKE2_SEQ_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                   clk;
    logic                   reset_n;
    logic                   init_s, next_s, final_s;
    logic [BLOCK_BITS-1:0]  block_s;
    logic [CTR_BITS-1:0]    length_s;
    logic                   ready_w, digest_valid_w, err_w;
    logic [DIGEST_BITS-1:0] digest_w;
    logic                   core_valid_w, core_first_w, core_last_w;
    logic [BLOCK_BITS-1:0]  core_block_w;
    logic [CTR_BITS-1:0]    core_t_w;
    logic                   core_ready_s, core_dv_s;
    logic [DIGEST_BITS-1:0] core_digest_s;

    blake2_block_sequencer #(
        .BLOCK_BITS (BLOCK_BITS),
        .DEPTH      (DEPTH),
        .DIGEST_BITS(DIGEST_BITS),
        .CTR_BITS   (CTR_BITS)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .init_i             (init_s),
        .next_i             (next_s),
        .final_i            (final_s),
        .block_i            (block_s),
        .length_i           (length_s),
        .ready_o            (ready_w),
        .digest_valid_o     (digest_valid_w),
        .digest_o           (digest_w),
        .err_o              (err_w),
        .core_valid_o       (core_valid_w),
        .core_block_o       (core_block_w),
        .core_first_o       (core_first_w),
        .core_last_o        (core_last_w),
        .core_t_o           (core_t_w),
        .core_ready_i       (core_ready_s),
        .core_digest_valid_i(core_dv_s),
        .core_digest_i      (core_digest_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BLOCK_BITS-1:0] blk;
        logic                  first;
        logic                  last;
        logic [CTR_BITS-1:0]   t;
    } ent_t;

    // reference model
    ent_t                   m_q[$];
    bit                     m_open, m_closed, m_wait, m_dv, m_err;
    logic [DIGEST_BITS-1:0] m_dig;
    logic [127:0]           m_nblk;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           xfers;
    logic [127:0] obs_t[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BLOCK_BITS-1:0] rand_blk();
        logic [BLOCK_BITS-1:0] b;
        for (int i = 0; i < BLOCK_BITS / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_open = 0; m_closed = 0; m_wait = 0; m_dv = 0; m_err = 0;
        m_dig = '0; m_nblk = '0;
    endtask

    // One clock: drive inputs, check outputs at the falling edge, advance the model.
    task automatic cycle(input logic ini, input logic nxt, input logic fin,
                         input logic [BLOCK_BITS-1:0] blk, input logic [127:0] len,
                         input logic crdy, input logic cdv, input logic [DIGEST_BITS-1:0] cdig);
        bit idle, rdy, viol, pop;
        int n;
        ent_t e;
        init_s = ini; next_s = nxt; final_s = fin; block_s = blk; length_s = len;
        core_ready_s = crdy; core_dv_s = cdv; core_digest_s = cdig;
        @(negedge clk);
        idle = !m_open && !m_closed;
        rdy  = idle || (m_open && m_q.size() < DEPTH);
        chk("ready", 128'(ready_w), 128'(rdy));
        chk("core_valid", 128'(core_valid_w), 128'(m_q.size() != 0));
        chk("digest_valid", 128'(digest_valid_w), 128'(m_dv));
        chk("err", 128'(err_w), 128'(m_err));
        if (m_dv) chk("digest", 128'(digest_w), 128'(m_dig));
        if (m_q.size() != 0) begin
            chk("core_first", 128'(core_first_w), 128'(m_q[0].first));
            chk("core_last", 128'(core_last_w), 128'(m_q[0].last));
            chk("core_t", core_t_w, m_q[0].t);
        end
        pop = (m_q.size() != 0) && crdy;
        if (pop) begin
            for (int i = 0; i < BLOCK_BITS / 128; i++)
                chk($sformatf("core_block%0d", i), core_block_w[i*128 +: 128], m_q[0].blk[i*128 +: 128]);
            obs_t.push_back(core_t_w);
            xfers++;
        end
        if (m_wait && cdv) begin
            m_dig = cdig; m_dv = 1; m_wait = 0; m_closed = 0;
        end
        if (pop) begin
            if (m_q[0].last) m_wait = 1;
            void'(m_q.pop_front());
        end
        n = int'(ini) + int'(nxt) + int'(fin);
        viol = 0;
        if (n != 0) begin
            if (rdy && idle && ini && !nxt) begin
                m_dv = 0; m_err = 0;
                e.blk = blk; e.first = 1; e.last = fin;
                e.t = fin ? len : BYTES;
                m_q.push_back(e);
                m_nblk = 128'd1;
                m_open = !fin; m_closed = fin;
            end else if (rdy && m_open && n == 1 && nxt) begin
                e.blk = blk; e.first = 0; e.last = 0;
                e.t = (m_nblk + 128'd1) * BYTES;
                m_q.push_back(e);
                m_nblk = m_nblk + 128'd1;
            end else if (rdy && m_open && n == 1 && fin) begin
                e.blk = blk; e.first = 0; e.last = 1; e.t = len;
                m_q.push_back(e);
                m_open = 0; m_closed = 1;
            end else begin
                viol = 1;
            end
        end
        if (viol && ERR_EN) m_err = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc(input logic crdy);
        cycle(0, 0, 0, '0, '0, crdy, 0, '0);
    endtask

    task automatic strobe(input logic ini, input logic nxt, input logic fin,
                          input logic [127:0] len, input logic crdy);
        cycle(ini, nxt, fin, rand_blk(), len, crdy, 0, '0);
    endtask

    // Drain with core_ready high and answer WAIT_DIG with the given digest.
    task automatic run_until_done(input logic [DIGEST_BITS-1:0] dig, input int budget);
        int k;
        k = 0;
        while (!m_dv && k < budget) begin
            cycle(0, 0, 0, '0, '0, 1'b1, m_wait, dig);
            k++;
        end
        if (!m_dv) chk("done_timeout", 128'd0, 128'd1);
    endtask

    task automatic do_reset();
        reset_n = 0;
        init_s = 0; next_s = 0; final_s = 0; block_s = '0; length_s = '0;
        core_ready_s = 0; core_dv_s = 0; core_digest_s = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        #1;
        chk("rst_ready", 128'(ready_w), 128'd1);
        chk("rst_core_valid", 128'(core_valid_w), 128'd0);
        chk("rst_digest_valid", 128'(digest_valid_w), 128'd0);
        chk("rst_digest", 128'(digest_w), 128'd0);
        chk("rst_err", 128'(err_w), 128'd0);
    endtask

    initial begin
        logic [BLOCK_BITS-1:0] abc;
        logic [127:0]          exp_t [4];
        int                    r;
        logic                  ini, nxt, fin;

        reset_n = 0;
        do_reset();

        // single-block message "abc"
        abc = '0;
        abc[23:0] = 24'h616263;
        xfers = 0;
        cycle(1, 0, 1, abc, 128'd3, 1'b1, 0, '0);
        run_until_done(88'h1234, 20);
        chk("abc_xfers", 128'(xfers), 128'd1);
        chk("abc_dv", 128'(digest_valid_w), 128'd1);
        chk("abc_digest", 128'(digest_w), 128'h1234);

        // four-block message, length 400
        obs_t.delete();
        strobe(1, 0, 0, '0, 1'b1);
        strobe(0, 1, 0, '0, 1'b1);
        strobe(0, 1, 0, '0, 1'b1);
        strobe(0, 0, 1, 128'd400, 1'b1);
        run_until_done(88'hABCDEF, 30);
        exp_t[0] = 128'd128; exp_t[1] = 128'd256; exp_t[2] = 128'd384; exp_t[3] = 128'd400;
        chk("len400_count", 128'(obs_t.size()), 128'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("len400_t%0d", i), (i < obs_t.size()) ? obs_t[i] : '1, exp_t[i]);

        // fill FIFO with core stalled, then overflow strobe
        do_reset();
        strobe(1, 0, 0, '0, 1'b0);
        for (int i = 0; i < 7; i++) strobe(0, 1, 0, '0, 1'b0);
        chk("full_ready", 128'(ready_w), 128'd0);
        strobe(0, 1, 0, '0, 1'b0);
        chk("overflow_err", 128'(err_w), 128'(ERR_EN));
        // pop and push together on a full FIFO: push rejected
        strobe(0, 1, 0, '0, 1'b1);
        chk("pp_ready", 128'(ready_w), 128'd1);
        strobe(0, 0, 1, 128'd1000, 1'b0);
        chk("refill_ready", 128'(ready_w), 128'd0);
        run_until_done(88'h55, 40);

        // reset mid-message
        strobe(1, 0, 0, '0, 1'b0);
        strobe(0, 1, 0, '0, 1'b0);
        strobe(0, 1, 0, '0, 1'b0);
        chk("mid_core_valid", 128'(core_valid_w), 128'd1);
        do_reset();
        repeat (3) idle_cyc(1'b1);
        xfers = 0;
        cycle(1, 0, 1, abc, 128'd3, 1'b1, 0, '0);
        run_until_done(88'h777, 20);
        chk("post_rst_xfers", 128'(xfers), 128'd1);
        chk("post_rst_digest", 128'(digest_w), 128'h777);

        // next in IDLE, then init while FILL
        do_reset();
        strobe(0, 1, 0, '0, 1'b0);
        chk("next_idle_err", 128'(err_w), 128'(ERR_EN));
        chk("next_idle_cv", 128'(core_valid_w), 128'd0);
        strobe(1, 0, 0, '0, 1'b0);
        chk("init_clr_err", 128'(err_w), 128'd0);
        strobe(1, 0, 0, '0, 1'b0);
        chk("init_fill_err", 128'(err_w), 128'(ERR_EN));
        strobe(0, 0, 1, 128'd200, 1'b1);
        run_until_done(88'h99, 20);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            if (!m_open && !m_closed) begin
                ini = (r < 40); nxt = (r >= 90); fin = (r >= 30 && r < 50);
            end else begin
                ini = (r < 4); nxt = (r >= 10 && r < 50); fin = (r >= 50 && r < 60);
            end
            if ($urandom_range(0, 24) == 0) nxt = 1'b1;
            cycle(ini, nxt, fin, rand_blk(), rand128(),
                  ($urandom_range(0, 99) < 60),
                  m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0),
                  DIGEST_BITS'(rand128()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/blake2_block_sequencer.md
BLAKE2_BLOCK_SEQUENCER -- requirements
Module: blake2_block_sequencer

Interface
REQ-001 Parameters (name, default, meaning): BLOCK_BITS, 1024, block width (512 selects BLAKE2s); DEPTH, 8, block FIFO entries, power of two, >=2; DIGEST_BITS, 88, captured digest width; CTR_BITS, 128, byte-counter and length width.
REQ-002 Ports (name direction width meaning): clk in 1 clock; reset_n in 1 asynchronous active-low reset; one clock, reset asynchronous active-low.
REQ-003 init in 1 first-block strobe; next in 1 middle-block strobe; final in 1 last-block strobe; block in BLOCK_BITS block data; length in CTR_BITS total message bytes, sampled with final.
REQ-004 ready out 1 host may strobe; digest_valid out 1 digest held; digest out DIGEST_BITS result; err out 1 sticky protocol-error flag.
REQ-005 core_valid out 1 block offered; core_block out BLOCK_BITS; core_first out 1; core_last out 1; core_t out CTR_BITS byte counter; core_ready in 1 core accepts; core_digest_valid in 1; core_digest in DIGEST_BITS.

Function
REQ-006 FSM states IDLE, FILL, DRAIN, WAIT_DIG, DONE.
REQ-007 IDLE/DONE: accepted init -> FILL (init+final same cycle = single-block message -> DRAIN); init clears digest_valid, t, err.
REQ-008 FILL: next pushes middle block; final pushes last block, latches length, -> DRAIN.
REQ-009 DRAIN: FIFO empties to core; handshake of entry tagged last -> WAIT_DIG.
REQ-010 WAIT_DIG: core_digest_valid high -> capture core_digest, -> DONE; digest_valid high the following cycle and held until next accepted init.
REQ-011 ready = 1 only in IDLE, DONE, or FILL with registered count < DEPTH; ready is from registered count, so a pop in the same cycle does not allow a push into a full FIFO.
REQ-012 A strobe is accepted only while ready=1; each FIFO entry stores block plus first/last tags.
REQ-013 core_valid = FIFO non-empty; core_block/first/last from head entry; transfer on core_valid & core_ready; no push-to-pop bypass, so minimum latency strobe-to-core_valid is 1 cycle.
REQ-014 core_valid and head entry stay stable until transfer.
REQ-015 core_t: non-last head = t + BLOCK_BITS/8; last head = latched length; t advances by BLOCK_BITS/8 on each non-last transfer; arithmetic modulo 2^CTR_BITS.
REQ-016 FIFO pointers wrap modulo DEPTH; simultaneous push and pop leaves count unchanged.
REQ-017 Protocol violations, dropped without state change: next/final in IDLE or DONE; init outside IDLE/DONE; any strobe while ready=0; more than one of init/next/final high except init+final.
REQ-018 core_digest_valid outside WAIT_DIG ignored.

Reset
REQ-019 reset_n low: state IDLE, FIFO pointers and count 0, t 0, latched length 0, digest 0, digest_valid 0, err 0, core_valid 0; ready 1 after release.
REQ-020 Reset mid-message discards all buffered blocks; no core output until the next init.

Configuration
REQ-021 Macro BLAKE2_SEQ_ERR_EN defined: violations of REQ-017 set err on the following cycle, cleared only by reset or accepted init.
REQ-022 BLAKE2_SEQ_ERR_EN undefined: violations silently dropped, err tied to 0, no error logic synthesised.

Verification
REQ-023 init+final, length=3, block "abc" -> one core transfer, first=1, last=1, core_t=3; core_digest 0x1234 -> digest_valid=1, digest=0x1234.
REQ-024 BLOCK_BITS=1024: init, 2x next, final length=400 -> core_t 128, 256, 384, 400; last only on fourth.
REQ-025 core_ready=0, DEPTH=8: init + 7 next -> ready=0 after 8th push; 9th strobe dropped; err=1 iff BLAKE2_SEQ_ERR_EN.
REQ-026 Full FIFO with pop and push same cycle -> push rejected, count 7 after pop, ready=1 next cycle.
REQ-027 reset_n low after 3 pushes -> core_valid=0, ready=1, digest_valid=0; new init+final message completes normally.
REQ-028 next in IDLE, then init while FILL -> no FIFO change; err=1 only when macro defined.
